// File: rtl/fp_pkg.sv
// Shared constants and types for the floating-point normalize/round slice.
//
// Contents:
//   EXP_W, MANT_W, BIAS, EXP_MAX - IEEE-754 single-precision field geometry
//   EXP_ARITH_W                  - width of the signed exponent datapath
//   RAW_W                        - width of the raw mantissa sum (carry + hidden + fraction)
//   POS_W                        - width of an encoded leading-one position
//   fp32_t                       - packed IEEE-754 single word
//   pack_fp                      - builds an fp32_t from its three fields
package fp_pkg;

    localparam int EXP_W       = 8;
    localparam int MANT_W      = 23;
    localparam int BIAS        = 127;
    localparam int EXP_MAX     = 255;
    localparam int EXP_ARITH_W = 10;
    localparam int RAW_W       = MANT_W + 2;
    localparam int POS_W       = 5;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp32_t;

    function automatic fp32_t pack_fp(input logic sign,
                                      input logic [EXP_W-1:0] exp,
                                      input logic [MANT_W-1:0] frac);
        fp32_t f;
        f.sign = sign;
        f.exp  = exp;
        f.frac = frac;
        return f;
    endfunction

endpackage

// File: rtl/pr_circuit_25x25.sv
// Priority circuit: one-hot grant of the most significant set request bit.
//
// Ports:
//   req   [24:0] in   request vector (raw mantissa sum)
//   grant [24:0] out  one-hot vector marking the highest set bit of req;
//                     all zeros when req is zero
module pr_circuit_25x25 (
    input  logic [24:0] req,
    output logic [24:0] grant
);

    logic found;

    // Scan from the MSB down; the first set bit wins and masks the rest.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 24; i >= 0; i--) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fp_normalize_round.sv
// Two-stage normalize / round / pack back end for a single-precision adder.
//
// Stage 1 registers the incoming beat together with the one-hot leading-one
// vector of the raw mantissa and its encoded position. Stage 2 shifts,
// adjusts the exponent, rounds and packs, and registers the result and flags.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   in_valid/in_ready input handshake
//   in_sign           sign of the raw sum
//   in_exp [7:0]      biased exponent of the larger operand (1..254)
//   in_mant [24:0]    raw mantissa sum (bit24 carry, bit23 hidden position)
//   in_guard          first bit dropped during alignment
//   in_sticky         OR of the remaining dropped bits
//   in_special        bypass: emit in_special_word unchanged
//   in_special_word   word to emit for special cases
//   out_valid/out_ready output handshake
//   out_result [31:0] packed IEEE-754 single
//   out_ovf, out_unf, out_zero  overflow, underflow-flush, exact-zero flags
//
// Handshake: a beat transfers on a rising edge where valid and ready are
// both high. A producer holds valid and its payload until the transfer; the
// result side holds out_result and flags stable while out_valid & !out_ready.
// in_ready is combinational from the stage occupancy and out_ready.
module fp_normalize_round
    import fp_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_mant,
    input  logic        in_guard,
    input  logic        in_sticky,
    input  logic        in_special,
    input  logic [31:0] in_special_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_ovf,
    output logic        out_unf,
    output logic        out_zero
);

    localparam logic signed [EXP_ARITH_W-1:0] EXP_OVF = EXP_ARITH_W'(EXP_MAX);

    // ------------------------------------------------------------------
    // Leading-one detection on the raw input
    // ------------------------------------------------------------------
    logic [RAW_W-1:0] lead_onehot;
    logic [POS_W-1:0] lead_pos;

    pr_circuit_25x25 u_lead (
        .req   (in_mant),
        .grant (lead_onehot)
    );

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < RAW_W; i++) begin
            if (lead_onehot[i]) begin
                lead_pos = lead_pos | POS_W'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Handshake / stage load enables
    // ------------------------------------------------------------------
    logic s1_valid;
    logic s2_load;
    logic s1_load;

    assign s2_load  = !out_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    // ------------------------------------------------------------------
    // Stage 1 registers
    // ------------------------------------------------------------------
    logic              s1_sign;
    logic [EXP_W-1:0]  s1_exp;
    logic [RAW_W-1:0]  s1_mant;
    logic              s1_guard;
    logic              s1_sticky;
    logic              s1_special;
    logic [31:0]       s1_word;
    logic [RAW_W-1:0]  s1_onehot;
    logic [POS_W-1:0]  s1_pos;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_sign    <= 1'b0;
            s1_exp     <= '0;
            s1_mant    <= '0;
            s1_guard   <= 1'b0;
            s1_sticky  <= 1'b0;
            s1_special <= 1'b0;
            s1_word    <= '0;
            s1_onehot  <= '0;
            s1_pos     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sign    <= in_sign;
                s1_exp     <= in_exp;
                s1_mant    <= in_mant;
                s1_guard   <= in_guard;
                s1_sticky  <= in_sticky;
                s1_special <= in_special;
                s1_word    <= in_special_word;
                s1_onehot  <= lead_onehot;
                s1_pos     <= lead_pos;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 combinational: shift, exponent adjust, round, pack
    // ------------------------------------------------------------------
    logic [POS_W-1:0]              lsh;
    logic [MANT_W:0]               mant_n;
    logic                          rnd_bit;
    logic                          stk_bit;
    logic signed [EXP_ARITH_W-1:0] exp_n;
    logic                          inc;
    logic [MANT_W+1:0]             sum;
    logic [MANT_W:0]               mant_r;
    logic signed [EXP_ARITH_W-1:0] exp_r;
    logic                          is_zero;
    logic [31:0]                   nx_result;
    logic                          nx_ovf;
    logic                          nx_unf;
    logic                          nx_zero;

    // Left-shift distance when the leading one sits below the hidden bit.
    assign lsh     = POS_W'(MANT_W) - s1_pos;
    assign is_zero = ~|s1_onehot;

    always_comb begin
        mant_n  = '0;
        rnd_bit = 1'b0;
        stk_bit = 1'b0;
        exp_n   = $signed({{(EXP_ARITH_W-EXP_W){1'b0}}, s1_exp});

        if (s1_onehot[MANT_W+1]) begin
            // Carry out of the add: renormalize right by one.
            mant_n  = s1_mant[MANT_W+1:1];
            exp_n   = exp_n + EXP_ARITH_W'(1);
            rnd_bit = s1_mant[0];
            stk_bit = s1_guard | s1_sticky;
        end else if (s1_onehot[MANT_W]) begin
            mant_n  = s1_mant[MANT_W:0];
            rnd_bit = s1_guard;
            stk_bit = s1_sticky;
        end else begin
            // Cancellation: the guard bit fills the first vacated position,
            // later ones are zero; nothing is left below the LSB to round.
            mant_n = (s1_mant[MANT_W:0] << lsh)
                   | ({{MANT_W{1'b0}}, s1_guard} << (lsh - POS_W'(1)));
            exp_n  = exp_n - $signed({{(EXP_ARITH_W-POS_W){1'b0}}, lsh});
        end
    end

    always_comb begin
        inc    = ROUND_EN && rnd_bit && (stk_bit || mant_n[0]);
        sum    = {1'b0, mant_n} + (MANT_W+2)'(inc);
        mant_r = sum[MANT_W:0];
        exp_r  = exp_n;
        // All-ones mantissa rounding up rolls over to the next binade.
        if (sum[MANT_W+1]) begin
            mant_r = {1'b1, {MANT_W{1'b0}}};
            exp_r  = exp_n + EXP_ARITH_W'(1);
        end
    end

    always_comb begin
        nx_result = '0;
        nx_ovf    = 1'b0;
        nx_unf    = 1'b0;
        nx_zero   = 1'b0;

        if (s1_special) begin
            nx_result = s1_word;
        end else if (is_zero || !mant_r[MANT_W]) begin
            // A nonzero sum always normalizes with its hidden bit set.
            nx_zero = 1'b1;
        end else if (exp_r >= EXP_OVF) begin
            nx_result = pack_fp(s1_sign, EXP_W'(EXP_MAX), '0);
            nx_ovf    = 1'b1;
        end else if (exp_r <= EXP_ARITH_W'(0)) begin
            nx_result = pack_fp(s1_sign, '0, '0);
            nx_unf    = 1'b1;
        end else begin
            nx_result = pack_fp(s1_sign, exp_r[EXP_W-1:0], mant_r[MANT_W-1:0]);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers (the outputs)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_ovf    <= 1'b0;
            out_unf    <= 1'b0;
            out_zero   <= 1'b0;
        end else if (s2_load) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_result <= nx_result;
                out_ovf    <= nx_ovf;
                out_unf    <= nx_unf;
                out_zero   <= nx_zero;
            end
        end
    end

endmodule

// File: doc/fp_normalize_round.md
FP_NORMALIZE_ROUND -- requirements
Module: fp_normalize_round

Interface
REQ-001 Parameter ROUND_EN, default 1, meaning: 1 = round-to-nearest-even, 0 = truncate.
REQ-002 clk  input  1  clock; every register updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 in_valid  input  1  input beat present.
REQ-005 in_ready  output  1  block accepts the beat this cycle.
REQ-006 in_sign  input  1  sign of the raw sum.
REQ-007 in_exp  input  8  biased exponent of the larger operand, 1..254.
REQ-008 in_mant  input  25  raw mantissa sum; bit24 = carry, bit23 = hidden-bit position.
REQ-009 in_guard, in_sticky  input  1 each  first dropped bit and OR of remaining dropped bits from alignment.
REQ-010 in_special  input  1  input is a special case (NaN/Inf/zero operand); bypass normalization.
REQ-011 in_special_word  input  32  IEEE word emitted when in_special=1.
REQ-012 out_valid  output  1  result present.
REQ-013 out_ready  input  1  consumer accepts the result.
REQ-014 out_result  output  32  packed IEEE-754 single.
REQ-015 out_ovf, out_unf, out_zero  output  1 each  overflow, underflow-flush and exact-zero flags.

Function
REQ-016 Pipeline SHALL have two register stages; latency from accepted input to out_valid SHALL be exactly 2 cycles with no stall.
REQ-017 Stage 1 SHALL register the 25-bit one-hot leading-one vector of in_mant, its encoded position p (0..24) and all inputs.
REQ-018 Stage 2 SHALL perform shift, exponent adjust, rounding and packing, and register the outputs.
REQ-019 p=24: mantissa right-shifted 1, exponent +1, round bit = in_mant[0], sticky = in_guard|in_sticky.
REQ-020 p=23: no shift, round bit = in_guard, sticky = in_sticky.
REQ-021 p<23: left shift by 23-p, exponent -(23-p), in_guard shifted into bit0 then zeros, round bit = 0, sticky = 0.
REQ-022 ROUND_EN=1: increment 24-bit mantissa when round & (sticky | lsb); carry-out SHALL set mantissa to 24'h800000 and exponent +1.
REQ-023 Exponent arithmetic SHALL use 10-bit signed width.
REQ-024 Final exponent ≥255 SHALL yield {sign,8'hFF,23'h0} with out_ovf=1.
REQ-025 Final exponent ≤0 SHALL yield {sign,31'h0} with out_unf=1 (no subnormals).
REQ-026 in_mant=0 (in_special=0) SHALL yield 32'h00000000 with out_zero=1.
REQ-027 in_special=1 SHALL yield in_special_word verbatim with all flags 0.
REQ-028 Stage 2 SHALL load when !out_valid | out_ready; stage 1 SHALL load when stage 1 is empty or stage 2 loads; in_ready SHALL equal the stage-1 load condition.
REQ-029 While out_valid & !out_ready, out_result and flags SHALL hold stable; no beat SHALL be dropped, duplicated or reordered.
REQ-030 Simultaneous input accept and output drain SHALL sustain one result per cycle.

Reset
REQ-031 rst=1 SHALL asynchronously clear both stage valids, out_valid, out_result, and all flags to 0; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-032 Reset mid-operation SHALL discard all in-flight beats; no result for them SHALL appear.

Structure
REQ-033 Package fp_pkg SHALL hold EXP_W=8, MANT_W=23, BIAS=127, EXP_MAX=255 and the packed-float typedef.
REQ-034 Leading-one detection SHALL instantiate pr_circuit_25x25; no other sub-module.

Verification
REQ-035 in_exp=127, in_mant=25'h1800000, guard=sticky=0 -> out_result=32'h40400000 two cycles later, flags 0.
REQ-036 in_exp=127, in_mant=25'h0000001 -> 32'h34000000; in_mant=0 -> 32'h00000000, out_zero=1.
REQ-037 in_exp=127, in_mant=25'h1000001 -> 32'h40000000 (tie, even kept); 25'h1000003 -> 32'h40000002 (rounded up).
REQ-038 in_exp=254, in_mant=25'h1000000, sign=1 -> 32'hFF800000, out_ovf=1; in_exp=1, in_mant=25'h0400000 -> 32'h00000000, out_unf=1.
REQ-039 Three back-to-back beats with out_ready=0 for 4 cycles -> in_ready low after two accepted; output held; all three results emerge in order once out_ready=1.
REQ-040 rst pulsed with two beats in flight -> out_valid=0 immediately; no stale result after release.
